// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage access unit.
//   state_e   : access FSM states (IDLE, ACCESS, WAIT, DONE)
//   DATA_W_DEF/ADDR_W_DEF : default data / word-address widths
//   REG_IDX_W : destination register index width
//   CNT_W     : width of the memory wait-cycle counter
package mem_stage_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned REG_IDX_W  = 5;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter timing the data-memory wait cycles.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   load_i      : load load_val_i (takes priority over dec_i)
//   load_val_i  : value loaded on load_i
//   dec_i       : decrement by one (saturates at 0)
//   zero_o      : count is 0
module mem_wait_counter
  import mem_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: accepts load/store/pass-through ops from EX/MEM, drives
// the data memory, waits MEM_LATENCY cycles and returns one result per op to
// MEM/WB. Upstream is stalled while an access is in flight.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   ex_valid/ex_mem_read/ex_mem_write/ex_alu_res/ex_store/ex_rd : EX/MEM op
//   stall                     : hold EX/MEM and earlier stages
//   mem_read/mem_write/mem_address/mem_wdata/mem_rdata : data memory port
//   wb_valid/wb_data/wb_rd/wb_is_load : result to MEM/WB (wb_valid is a pulse)
//   mem_fault                 : only with MEM_BOUNDS_CHECK_EN; pulses with
//                               wb_valid for an out-of-range load/store
// Build option: define MEM_BOUNDS_CHECK_EN to suppress accesses at addresses
// >= MEM_DEPTH and report them on mem_fault.
module mem_access_unit
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned MEM_DEPTH   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic                 ex_mem_read,
  input  logic                 ex_mem_write,
  input  logic [ADDR_W-1:0]    ex_alu_res,
  input  logic [DATA_W-1:0]    ex_store,
  input  logic [REG_IDX_W-1:0] ex_rd,
  output logic                 stall,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 wb_valid,
  output logic [DATA_W-1:0]    wb_data,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic                 wb_is_load
`ifdef MEM_BOUNDS_CHECK_EN
  ,
  output logic                 mem_fault
`endif
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = (MEM_LATENCY == 0) ? '0 : CNT_W'(MEM_LATENCY - 1);

  state_e state_q, state_d;

  logic                 accept, is_mem_op, oob, cnt_zero, capture;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [REG_IDX_W-1:0] rd_q;
  logic                 load_q, store_q, fault_q;
  logic                 wb_valid_q, wb_is_load_q;
  logic [DATA_W-1:0]    wb_data_q;
  logic [REG_IDX_W-1:0] wb_rd_q;

  assign is_mem_op = ex_mem_read | ex_mem_write;
  assign accept    = (state_q == IDLE) && ex_valid;

`ifdef MEM_BOUNDS_CHECK_EN
  assign oob = (ex_alu_res >= ADDR_W'(MEM_DEPTH));
`else
  assign oob = 1'b0;
`endif

  // Read data is sampled on the last cycle mem_read is high: end of ACCESS
  // when there is no wait, otherwise end of the final WAIT cycle.
  assign capture = ((state_q == ACCESS) && (MEM_LATENCY == 0)) ||
                   ((state_q == WAIT) && cnt_zero);

  mem_wait_counter u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == ACCESS),
    .load_val_i (WAIT_LOAD),
    .dec_i      (state_q == WAIT),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mem_op) state_d = ACCESS;
      ACCESS:  state_d = (MEM_LATENCY == 0) ? DONE : WAIT;
      WAIT:    if (cnt_zero) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes decode straight from the state register so they drop
  // asynchronously with reset.
  always_comb begin
    stall       = (state_q != IDLE);
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    if ((state_q == ACCESS) || (state_q == WAIT)) begin
      mem_address = addr_q;
      mem_wdata   = wdata_q;
      mem_read    = load_q & ~fault_q;
      mem_write   = store_q & ~fault_q & (state_q == ACCESS);
    end
  end

`ifdef MEM_BOUNDS_CHECK_EN
  logic wb_fault_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      load_q       <= 1'b0;
      store_q      <= 1'b0;
      fault_q      <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= '0;
      wb_rd_q      <= '0;
      wb_is_load_q <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      wb_fault_q   <= 1'b0;
`endif
    end else begin
      wb_valid_q <= 1'b0;
      if (accept && is_mem_op) begin
        addr_q  <= ex_alu_res;
        wdata_q <= ex_store;
        rd_q    <= ex_rd;
        load_q  <= ex_mem_read;
        // A load takes precedence when both controls are set.
        store_q <= ex_mem_write & ~ex_mem_read;
        fault_q <= oob;
      end else if (accept) begin
        wb_valid_q   <= 1'b1;
        wb_data_q    <= DATA_W'(ex_alu_res);
        wb_rd_q      <= ex_rd;
        wb_is_load_q <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
        wb_fault_q   <= 1'b0;
`endif
      end
      if (capture) begin
        wb_valid_q   <= 1'b1;
        wb_data_q    <= (load_q && !fault_q) ? mem_rdata : '0;
        wb_rd_q      <= rd_q;
        wb_is_load_q <= load_q;
`ifdef MEM_BOUNDS_CHECK_EN
        wb_fault_q   <= fault_q;
`endif
      end
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign wb_rd      = wb_rd_q;
  assign wb_is_load = wb_is_load_q;
`ifdef MEM_BOUNDS_CHECK_EN
  assign mem_fault  = wb_valid_q & wb_fault_q;
`endif

endmodule
